// File: rtl/div16x16_seq_if.sv
// -----------------------------------------------------------------------------
// div16x16_seq_if
// Handshake and data bundle for the iterative divider.
//   start        request a division (master -> slave)
//   signed_mode  1 = two's-complement operands, 0 = unsigned
//   dividend     numerator (Rs1 data)
//   divisor      denominator (Rs2 data)
//   busy         operation in flight (slave -> master)
//   done         one-cycle result-valid pulse
//   quotient     result, aluout1 equivalent
//   remainder    result, aluout2 equivalent
//   flag_zero    quotient == 0
//   flag_neg     quotient MSB
//   flag_ovf     signed -32768 / -1
//   flag_dbz     divisor was zero
// -----------------------------------------------------------------------------
interface div16x16_seq_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             signed_mode;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             flag_zero;
   logic             flag_neg;
   logic             flag_ovf;
   logic             flag_dbz;

   modport master (
      output start, signed_mode, dividend, divisor,
      input  busy, done, quotient, remainder,
      input  flag_zero, flag_neg, flag_ovf, flag_dbz
   );

   modport slave (
      input  start, signed_mode, dividend, divisor,
      output busy, done, quotient, remainder,
      output flag_zero, flag_neg, flag_ovf, flag_dbz
   );
endinterface

// File: rtl/div16x16_seq.sv
// -----------------------------------------------------------------------------
// div16x16_seq
// Restoring shift-subtract divider, one quotient bit per clock. Operands are
// converted to magnitudes at capture, divided unsigned, and the signs are
// re-applied when the result is registered.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      div16x16_seq_if.slave (start/operands in, busy/done/results out)
// Only WIDTH = 16 is supported.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; done pulse is cleared here
// RUN    | one shift/trial-subtract step per cycle, counter WIDTH-1 .. 0
// DONE   | register quotient/remainder/flags, pulse done, back to IDLE
// -----------------------------------------------------------------------------
module div16x16_seq #(
   parameter int WIDTH = 16
) (
   input  logic           clk,
   input  logic           reset_n,
   div16x16_seq_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] dvd_work;   // dividend magnitude, becomes quotient as bits shift in
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH-1:0] dvd_raw;    // untouched dividend, returned as remainder on divide by zero
   logic [WIDTH-1:0] prem;       // partial remainder; always < divisor so MSB of 17 never needed
   logic [CW-1:0]    cnt;
   logic             q_neg;
   logic             r_neg;
   logic             dbz;
   logic             ovf;

   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   rem_diff;
   logic [WIDTH-1:0] q_res;
   logic [WIDTH-1:0] r_res;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic              s);
      return (s && v[WIDTH-1]) ? ('0 - v) : v;
   endfunction

   always_comb begin
      rem_shift = {prem, dvd_work[WIDTH-1]};
      rem_diff  = rem_shift - {1'b0, dvs_mag};
      q_res     = dvd_work;
      r_res     = prem;
      if (dbz) begin
         q_res = '1;
         r_res = dvd_raw;
      end else begin
         // -32768 / -1 falls out naturally: magnitude 0x8000 negates to 0x8000
         if (q_neg) q_res = '0 - dvd_work;
         if (r_neg) r_res = '0 - prem;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         dvd_work      <= '0;
         dvs_mag       <= '0;
         dvd_raw       <= '0;
         prem          <= '0;
         cnt           <= '0;
         q_neg         <= 1'b0;
         r_neg         <= 1'b0;
         dbz           <= 1'b0;
         ovf           <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.quotient  <= '0;
         bus.remainder <= '0;
         bus.flag_zero <= 1'b0;
         bus.flag_neg  <= 1'b0;
         bus.flag_ovf  <= 1'b0;
         bus.flag_dbz  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  dvd_work <= magnitude(bus.dividend, bus.signed_mode);
                  dvs_mag  <= magnitude(bus.divisor, bus.signed_mode);
                  dvd_raw  <= bus.dividend;
                  q_neg    <= bus.signed_mode &
                              (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                  r_neg    <= bus.signed_mode & bus.dividend[WIDTH-1];
                  dbz      <= (bus.divisor == '0);
                  ovf      <= bus.signed_mode &&
                              (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                              (bus.divisor == '1);
                  prem     <= '0;
                  cnt      <= CW'(WIDTH - 1);
                  bus.busy <= 1'b1;
                  state    <= (bus.divisor == '0) ? S_DONE : S_RUN;
               end else begin
                  bus.busy <= 1'b0;
               end
            end

            S_RUN: begin
               // rem_diff MSB set means the trial subtract went negative: restore
               if (rem_diff[WIDTH]) begin
                  prem <= rem_shift[WIDTH-1:0];
               end else begin
                  prem <= rem_diff[WIDTH-1:0];
               end
               dvd_work <= {dvd_work[WIDTH-2:0], ~rem_diff[WIDTH]};
               if (cnt == '0) begin
                  state <= S_DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            S_DONE: begin
               bus.quotient  <= q_res;
               bus.remainder <= r_res;
               bus.flag_zero <= (q_res == '0);
               bus.flag_neg  <= q_res[WIDTH-1];
               bus.flag_ovf  <= ovf;
               bus.flag_dbz  <= dbz;
               bus.done      <= 1'b1;
               state         <= S_IDLE;
            end

            default: begin
               state    <= S_IDLE;
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_div16x16_seq.sv
// -----------------------------------------------------------------------------
// tb_div16x16_seq
// Directed and random divisions checked against an integer-arithmetic model.
// -----------------------------------------------------------------------------
module tb_div16x16_seq;
   logic clk = 1'b0;
   logic reset_n = 1'b0;

   always #5 clk = ~clk;

   div16x16_seq_if #(.WIDTH(16)) bus ();

   div16x16_seq #(.WIDTH(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct packed {
      logic [15:0] q;
      logic [15:0] r;
      logic        z;
      logic        n;
      logic        o;
      logic        d;
   } res_t;

   int   n_checks = 0;
   int   n_errors = 0;
   res_t last_exp;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input bit s);
      res_t m;
      int   sa;
      int   sb;
      if (b == 16'd0) begin
         m.q = 16'hFFFF;
         m.r = a;
      end else if (s) begin
         sa  = int'($signed(a));
         sb  = int'($signed(b));
         m.q = 16'(sa / sb);
         m.r = 16'(sa % sb);
      end else begin
         m.q = a / b;
         m.r = a % b;
      end
      m.z = (m.q == 16'd0);
      m.n = m.q[15];
      m.o = s && (a == 16'h8000) && (b == 16'hFFFF);
      m.d = (b == 16'd0);
      return m;
   endfunction

   task automatic check_outputs(input string tag, input res_t e);
      chk({tag, ".q"},    32'(bus.quotient),  32'(e.q));
      chk({tag, ".r"},    32'(bus.remainder), 32'(e.r));
      chk({tag, ".zero"}, 32'(bus.flag_zero), 32'(e.z));
      chk({tag, ".neg"},  32'(bus.flag_neg),  32'(e.n));
      chk({tag, ".ovf"},  32'(bus.flag_ovf),  32'(e.o));
      chk({tag, ".dbz"},  32'(bus.flag_dbz),  32'(e.d));
   endtask

   // Launches one division; poke pulses a second start mid-run which must be
   // ignored. Inputs change 1 unit after the rising edge, outputs sampled there too.
   task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input bit s, input bit poke);
      res_t e;
      int   lat;
      int   nbusy;
      int   extra;
      e = model(a, b, s);
      bus.start       = 1'b1;
      bus.dividend    = a;
      bus.divisor     = b;
      bus.signed_mode = s;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk({tag, ".busy_e0"}, 32'(bus.busy), 32'd1);
      chk({tag, ".done_e0"}, 32'(bus.done), 32'd0);
      lat   = 0;
      nbusy = 1;
      while (!bus.done && lat < 40) begin
         if (lat == 3) chk({tag, ".hold_q"}, 32'(bus.quotient), 32'(last_exp.q));
         if (poke && lat == 5) begin
            bus.start       = 1'b1;
            bus.dividend    = 16'h1234;
            bus.divisor     = 16'h0003;
            bus.signed_mode = ~s;
         end
         if (poke && lat == 6) bus.start = 1'b0;
         @(posedge clk); #1;
         lat++;
         if (bus.busy) nbusy++;
      end
      chk({tag, ".latency"}, 32'(lat), (b == 16'd0) ? 32'd1 : 32'd17);
      check_outputs(tag, e);
      last_exp = e;
      @(posedge clk); #1;
      chk({tag, ".done_fall"}, 32'(bus.done), 32'd0);
      chk({tag, ".busy_fall"}, 32'(bus.busy), 32'd0);
      chk({tag, ".busy_cyc"}, 32'(nbusy), (b == 16'd0) ? 32'd2 : 32'd18);
      if (poke) begin
         extra = 0;
         for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (bus.done) extra++;
         end
         chk({tag, ".no_2nd_done"}, 32'(extra), 32'd0);
         check_outputs({tag, ".kept"}, e);
      end
   endtask

   task automatic check_reset_state(input string tag);
      res_t z;
      z = '0;
      chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
      chk({tag, ".done"}, 32'(bus.done), 32'd0);
      check_outputs(tag, z);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] a;
      logic [15:0] b;
      bit          s;
      bus.start       = 1'b0;
      bus.signed_mode = 1'b0;
      bus.dividend    = '0;
      bus.divisor     = '0;
      last_exp        = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      reset_n = 1'b1;
      @(posedge clk); #1;

      run_div("u100_7",   16'd100,  16'd7,     1'b0, 1'b0);
      run_div("uffff_1",  16'hFFFF, 16'd1,     1'b0, 1'b0);
      run_div("u5_9",     16'd5,    16'd9,     1'b0, 1'b0);
      run_div("s_m7_2",   16'hFFF9, 16'h0002,  1'b1, 1'b0);
      run_div("s_7_m2",   16'h0007, 16'hFFFE,  1'b1, 1'b0);
      run_div("dbz",      16'd1234, 16'd0,     1'b0, 1'b0);
      run_div("s_dbz",    16'h8001, 16'd0,     1'b1, 1'b0);
      run_div("s_ovf",    16'h8000, 16'hFFFF,  1'b1, 1'b0);
      run_div("u8000_ff", 16'h8000, 16'hFFFF,  1'b0, 1'b0);
      run_div("poke",     16'd100,  16'd7,     1'b0, 1'b1);

      // abort mid-run: reset lands in RUN cycle 8
      bus.start       = 1'b1;
      bus.dividend    = 16'd4321;
      bus.divisor     = 16'd13;
      bus.signed_mode = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check_reset_state("abort");
      last_exp = '0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      run_div("after_abort", 16'd100, 16'd7, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         s = 1'($urandom);
         case ($urandom_range(0, 7))
            0: b = 16'd0;
            1: b = 16'($urandom_range(1, 5));
            2: b = s ? 16'hFFFF : 16'd1;
            3: a = 16'h8000;
            default: ;
         endcase
         run_div($sformatf("rnd%0d", i), a, b, s, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/div16x16_seq.md
# div16x16_seq

Iterative 16-bit divider that complements the combinational `mult16x16`. It computes quotient and remainder for the CPU's divide operations over 16 cycles, one quotient bit per clock, using a restoring shift-subtract algorithm. It sits beside the ALU: operands come from the Rs1 and Rs2 register read ports, and the results are written back through the same path as `aluout1` and `aluout2`. Status flags use the same bit meanings as the ALU status register.

## Interface
Parameters:
- `WIDTH`, default 16: operand width. Only 16 is supported.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a division. Sampled only in IDLE.
- `signed_mode`  in  1  1 = two's-complement operands, 0 = unsigned. Sampled together with `start`.
- `dividend`  in  16  numerator (Rs1 data). Sampled together with `start`.
- `divisor`  in  16  denominator (Rs2 data). Sampled together with `start`.
- `busy`  out  1  high from the capture edge until `done` falls.
- `done`  out  1  one-cycle pulse; results are valid from this cycle onward.
- `quotient`  out  16  result, written back as the `aluout1` equivalent.
- `remainder`  out  16  result, written back as the `aluout2` equivalent.
- `flag_zero`  out  1  quotient == 0.
- `flag_neg`  out  1  quotient[15].
- `flag_ovf`  out  1  signed overflow (-32768 / -1).
- `flag_dbz`  out  1  divisor was zero.

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset: state = IDLE. `busy`, `done`, `quotient`, `remainder` and all four flags are 0.
- IDLE with `start`=1:
  - Capture the operands.
  - In signed mode, convert each operand to its magnitude and record `q_neg` (operand signs differ) and `r_neg` (dividend negative).
  - Clear the 17-bit partial remainder and set the iteration counter to 15.
  - Next state is RUN, or DONE directly if the divisor is 0.
- RUN, once per cycle:
  - Shift the working dividend MSB into the partial remainder.
  - Trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - When the counter reaches 0, go to DONE; otherwise decrement the counter.
- DONE:
  - Register the outputs and pulse `done` for one cycle, then return to IDLE.
  - In signed mode, negate the quotient if `q_neg` is set and negate the remainder if `r_neg` is set.
- Divide by zero:
  - `quotient` = 16'hFFFF, `remainder` = the raw dividend.
  - `flag_dbz`=1; `flag_zero` and `flag_neg` are computed from 16'hFFFF.
- Signed 16'h8000 / 16'hFFFF:
  - `quotient` = 16'h8000, `remainder` = 0.
  - `flag_ovf`=1, `flag_neg`=1.
- `flag_ovf` and `flag_dbz` are 0 in all other cases. The flags are updated only in DONE.
- `start` while `busy`=1 is ignored; no queueing.
- Outputs and flags hold the last result until the next DONE. They do not change on capture or during RUN.
- Reset asserted mid-operation aborts immediately. All outputs return to their reset values and no `done` pulse is produced.

## Timing
- Capture edge E0: `busy` rises after E0.
- Normal latency: RUN covers E1..E16. The DONE update occurs at E17, so `done`=1 and the results are valid in the cycle following E17. `done` and `busy` fall after E18.
- Divide-by-zero latency: DONE at E1, `done` valid in the cycle after E1.
- Earliest re-accepted `start` is the first IDLE cycle, i.e. sampled at E18 for normal operation. Throughput is one division per 18 cycles.
- `start` held continuously: a new division begins at every IDLE cycle.
- The outputs are registered and there is no combinational path from the inputs to the outputs.

## Test plan
- Unsigned 100 / 7 -> `quotient`=14, `remainder`=2, `flag_zero`=0; `done` pulse exactly 17 edges after the capture edge; `busy` high for 18 cycles.
- Unsigned 16'hFFFF / 1 -> `quotient`=16'hFFFF, `remainder`=0, `flag_neg`=1. Then 5 / 9 -> `quotient`=0, `remainder`=5, `flag_zero`=1.
- Signed -7 / 2 (16'hFFF9, 16'h0002) -> `quotient`=16'hFFFD, `remainder`=16'hFFFF. Signed 7 / -2 -> `quotient`=16'hFFFD, `remainder`=1.
- Divide by zero, 1234 / 0 -> `done` one edge after capture; `quotient`=16'hFFFF, `remainder`=1234, `flag_dbz`=1. Signed 16'h8000 / 16'hFFFF -> `quotient`=16'h8000, `remainder`=0, `flag_ovf`=1.
- `start` pulsed with new operands 5 cycles into a division -> ignored; the first result is unchanged and no second `done` occurs.
- `reset_n` low at cycle 8 of RUN -> `busy`=0, `done`=0, all outputs 0 immediately. After release, 100 / 7 completes normally.
